mac_dot_seq: RTL and testbench

Sequencer that drives one combinational 16x16 MAC unit (R = A*B + C, 16-bit C, 32-bit R) to compute an unsigned dot product over a programmable number of operand pairs. Operand pairs arrive on a valid/ready stream. The MAC result is registered once and summed into a wide accumulator, and the final sum is presented on a valid/ready output. The block sits between the operand source and the approximate MAC datapath, and owns all sequencing and accumulation.

---
 rtl/mac_dot_seq_if.sv | 27 ++
 rtl/mac_dot_seq.sv | 104 ++++++++++
 tb/tb_mac_dot_seq.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mac_dot_seq_if.sv
// rtl/mac_dot_seq_if.sv - operand stream, result stream and MAC bus of mac_dot_seq
interface mac_dot_seq_if #(
  parameter int ACC_W = 40
);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_a;
  logic [15:0]      in_b;
  logic [15:0]      mac_a;
  logic [15:0]      mac_b;
  logic [15:0]      mac_c;
  logic [31:0]      mac_r;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_data;
  logic             out_ovf;

  modport master (
    output in_valid, in_a, in_b, out_ready, mac_r,
    input  in_ready, out_valid, out_data, out_ovf, mac_a, mac_b, mac_c
  );

  modport slave (
    input  in_valid, in_a, in_b, out_ready, mac_r,
    output in_ready, out_valid, out_data, out_ovf, mac_a, mac_b, mac_c
  );
endinterface

// File: rtl/mac_dot_seq.sv
// rtl/mac_dot_seq.sv - unsigned dot-product sequencer around a combinational 16x16 MAC
// Define MAC_DOT_SEQ_SAT_EN for a saturating accumulator with sticky overflow flag.
module mac_dot_seq #(
  parameter int LEN_W = 8,
  parameter int ACC_W = 40
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [15:0]      bias,
  output logic             busy,
  mac_dot_seq_if.slave     bus
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t           state;
  state_t           state_nx;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt;
  logic [15:0]      bias_q;
  logic [31:0]      prod;
  logic             p_vld;
  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] acc_add;
  logic             accept;
  logic             last_acc;

`ifdef MAC_DOT_SEQ_SAT_EN
  logic             ovf;
  logic [ACC_W:0]   sum;
`endif

  assign busy          = (state != IDLE);
  assign bus.in_ready  = (state == RUN);
  assign bus.out_valid = (state == DONE);
  assign bus.out_data  = acc;
  assign bus.mac_a     = bus.in_a;
  assign bus.mac_b     = bus.in_b;
  // Bias enters through the first product only, so it is counted once per job.
  assign bus.mac_c     = (cnt == '0) ? bias_q : 16'd0;

  assign accept   = bus.in_valid & (state == RUN);
  assign last_acc = accept & (cnt == len_q - LEN_W'(1));

`ifdef MAC_DOT_SEQ_SAT_EN
  assign sum         = {1'b0, acc} + {{(ACC_W-31){1'b0}}, prod};
  assign acc_add     = sum[ACC_W] ? '1 : sum[ACC_W-1:0];
  assign bus.out_ovf = ovf & (state == DONE);
`else
  assign acc_add     = acc + ACC_W'(prod);
  assign bus.out_ovf = 1'b0;
`endif

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (len == '0) ? DONE : RUN;
      RUN:     if (last_acc) state_nx = DRAIN;
      DRAIN:   state_nx = DONE;
      DONE:    if (bus.out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      len_q  <= '0;
      cnt    <= '0;
      bias_q <= '0;
      prod   <= '0;
      p_vld  <= 1'b0;
      acc    <= '0;
`ifdef MAC_DOT_SEQ_SAT_EN
      ovf    <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      p_vld <= accept;
      if (state == IDLE && start) begin
        len_q  <= len;
        bias_q <= bias;
        cnt    <= '0;
        // An empty job still reports the bias as its result.
        acc    <= (len == '0) ? ACC_W'(bias) : '0;
`ifdef MAC_DOT_SEQ_SAT_EN
        ovf    <= 1'b0;
`endif
      end else if (p_vld) begin
        acc <= acc_add;
`ifdef MAC_DOT_SEQ_SAT_EN
        if (sum[ACC_W]) ovf <= 1'b1;
`endif
      end
      if (accept) begin
        prod <= bus.mac_r;
        cnt  <= cnt + LEN_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_mac_dot_seq.sv
// tb/tb_mac_dot_seq.sv - scoreboard bench for mac_dot_seq with a behavioural dot-product model
module tb_mac_dot_seq;
  localparam int LEN_W = 8;
  localparam int ACC_W = 33;
  localparam longint ACC_MAX = (longint'(1) << ACC_W) - 1;

  typedef struct {
    longint data;
    logic   ovf;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic [15:0]      bias = '0;
  logic             busy;

  mac_dot_seq_if #(.ACC_W(ACC_W)) bus ();

  mac_dot_seq #(.LEN_W(LEN_W), .ACC_W(ACC_W)) dut (
    .clk(clk),
    .rst(rst),
    .start(start),
    .len(len),
    .bias(bias),
    .busy(busy),
    .bus(bus)
  );

  always #5 clk = ~clk;

  // Exact MAC model: R = A*B + C.
  assign bus.mac_r = 32'(bus.mac_a) * 32'(bus.mac_b) + 32'(bus.mac_c);

  int   total = 0;
  int   bad = 0;
  exp_t sb[$];
  int   pa[$];
  int   pb[$];
  int   cyc = 0;
  int   acc_cnt = 0;
  int   last_acc_cyc = 0;
  int   rise_cyc = -1;
  logic prev_ov = 1'b0;
  logic ir_seen = 1'b0;
  logic rdy_drop = 1'b0;
  logic rnd_or = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endtask

  function automatic exp_t model(input int n, input int b);
    exp_t   e;
    longint s;
    s = longint'(b);
    for (int i = 0; i < n; i++) s += longint'(pa[i]) * longint'(pb[i]);
`ifdef MAC_DOT_SEQ_SAT_EN
    e.data = (s > ACC_MAX) ? ACC_MAX : s;
    e.ovf  = (s > ACC_MAX);
`else
    e.data = s & ACC_MAX;
    e.ovf  = 1'b0;
`endif
    return e;
  endfunction

  initial forever begin
    @(posedge clk);
    cyc = cyc + 1;
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (rnd_or) bus.out_ready = 1'($urandom_range(0, 1));
  end

  // Monitor: counts accepts, tracks out_valid rise, checks every result handshake.
  initial forever begin
    exp_t e;
    @(negedge clk);
    if (bus.in_valid && bus.in_ready) begin
      acc_cnt = acc_cnt + 1;
      last_acc_cyc = cyc;
    end
    if (bus.in_ready) ir_seen = 1'b1;
    if (bus.out_valid && !prev_ov) rise_cyc = cyc;
    prev_ov = bus.out_valid;
    if (bus.out_valid && bus.out_ready) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_output: got %0d expected none", bus.out_data);
      end else begin
        e = sb.pop_front();
        chk("out_data", 64'(bus.out_data), 64'(e.data));
        chk("out_ovf", 64'(bus.out_ovf), 64'(e.ovf));
      end
    end
  end

  task automatic go(input int n, input int b);
    @(posedge clk); #1;
    len = LEN_W'(n);
    bias = 16'(b);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic feed(input int n, input int gap, input bit rnd_gap);
    int   g;
    int   w;
    logic r;
    for (int i = 0; i < n; i++) begin
      g = rnd_gap ? int'($urandom_range(0, 3)) : gap;
      repeat (g) begin
        bus.in_valid = 1'b0;
        bus.in_a = 16'($urandom);
        bus.in_b = 16'($urandom);
        @(negedge clk);
        if (!bus.in_ready) rdy_drop = 1'b1;
        @(posedge clk); #1;
      end
      bus.in_valid = 1'b1;
      bus.in_a = 16'(pa[i]);
      bus.in_b = 16'(pb[i]);
      w = 0;
      do begin
        @(negedge clk);
        r = bus.in_ready;
        @(posedge clk); #1;
        w++;
      end while (!r && w < 50);
      if (!r) begin
        total++;
        bad++;
        $display("FAIL accept_timeout: got in_ready=0 expected 1");
      end
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int w = 0;
    while (busy !== 1'b0 && w < bound) begin
      @(posedge clk); #1;
      w++;
    end
    if (busy !== 1'b0) begin
      total++;
      bad++;
      $display("FAIL idle_timeout: got busy=%0b expected 0", busy);
    end
  endtask

  task automatic wait_out(input int bound);
    int w = 0;
    do begin
      @(negedge clk);
      w++;
    end while (!bus.out_valid && w < bound);
    if (!bus.out_valid) begin
      total++;
      bad++;
      $display("FAIL out_timeout: got out_valid=0 expected 1");
    end
  endtask

  task automatic run_job(input int n, input int b, input int gap, input bit rnd_gap);
    sb.push_back(model(n, b));
    go(n, b);
    feed(n, gap, rnd_gap);
    wait_idle(300);
  endtask

  initial begin
    int   a0;
    exp_t e;
    int   n;
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.out_ready = 1'b1;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_in_ready", 64'(bus.in_ready), 0);
    chk("rst_out_valid", 64'(bus.out_valid), 0);
    chk("rst_out_ovf", 64'(bus.out_ovf), 0);
    chk("rst_out_data", 64'(bus.out_data), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Back-to-back pairs
    pa = '{2, 4, 6};
    pb = '{3, 5, 7};
    a0 = acc_cnt;
    run_job(3, 5, 0, 1'b0);
    chk("s1_accepts", 64'(acc_cnt - a0), 3);
    chk("s1_latency", 64'(rise_cyc - last_acc_cyc), 2);

    // Gapped pairs: in_ready must stay high across the gaps
    rdy_drop = 1'b0;
    a0 = acc_cnt;
    run_job(3, 5, 2, 1'b0);
    chk("s2_accepts", 64'(acc_cnt - a0), 3);
    chk("s2_ready_held", 64'(rdy_drop), 0);

    // Empty job
    ir_seen = 1'b0;
    pa.delete();
    pb.delete();
    sb.push_back(model(0, 9));
    go(0, 9);
    @(negedge clk);
    chk("s3_out_valid", 64'(bus.out_valid), 1);
    wait_idle(20);
    chk("s3_no_in_ready", 64'(ir_seen), 0);

    // Back-pressure with a stray start in DONE
    pa = '{2, 4, 6};
    pb = '{3, 5, 7};
    bus.out_ready = 1'b0;
    e = model(3, 5);
    sb.push_back(e);
    go(3, 5);
    feed(3, 0, 1'b0);
    wait_out(20);
    @(posedge clk); #1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk("s4_hold_valid", 64'(bus.out_valid), 1);
      chk("s4_hold_data", 64'(bus.out_data), 64'(e.data));
      chk("s4_hold_busy", 64'(busy), 1);
      @(posedge clk); #1;
      start = (k == 1);
      len = 8'd1;
      bias = 16'd0;
    end
    start = 1'b0;
    bus.out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    chk("s4_release_valid", 64'(bus.out_valid), 0);
    chk("s4_release_busy", 64'(busy), 0);

    // Reset mid-job
    pa = '{7, 8, 9};
    pb = '{10, 11, 12};
    go(3, 1);
    feed(2, 0, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("s5_busy", 64'(busy), 0);
    chk("s5_in_ready", 64'(bus.in_ready), 0);
    chk("s5_out_valid", 64'(bus.out_valid), 0);
    pa = '{1};
    pb = '{1};
    run_job(1, 0, 0, 1'b0);

    // Randomized jobs with random gaps and back-pressure
    rnd_or = 1'b1;
    for (int j = 0; j < 8; j++) begin
      n = int'($urandom_range(0, 10));
      pa.delete();
      pb.delete();
      for (int i = 0; i < n; i++) begin
        pa.push_back(int'($urandom_range(0, 65535)));
        pb.push_back(int'($urandom_range(0, 65535)));
      end
      run_job(n, int'($urandom_range(0, 65535)), 0, 1'b1);
    end
    rnd_or = 1'b0;
    @(posedge clk); #3;
    bus.out_ready = 1'b1;

    // Overflow boundary at ACC_W=33
    pa = '{65535, 65535, 65535, 65535};
    pb = '{65535, 65535, 65535, 65535};
    bus.out_ready = 1'b0;
    sb.push_back(model(4, 0));
    go(4, 0);
    feed(4, 0, 1'b0);
    wait_out(20);
`ifdef MAC_DOT_SEQ_SAT_EN
    chk("s6_data", 64'(bus.out_data), 64'd8589934591);
    chk("s6_ovf", 64'(bus.out_ovf), 1);
`else
    chk("s6_data", 64'(bus.out_data), 64'd8589410308);
    chk("s6_ovf", 64'(bus.out_ovf), 0);
`endif
    @(posedge clk); #1;
    bus.out_ready = 1'b1;
    wait_idle(20);
    @(negedge clk);
    chk("ovf_idle", 64'(bus.out_ovf), 0);

    chk("sb_empty", 64'(sb.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end
endmodule
